// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon result UART transmitter.
//   tx_state_e    : serialiser states (IDLE, START, DATA, STOP, DONE)
//   seq_state_e   : word sequencer states (idle, sending, done pulse)
//   CHAR_CR/LF    : line terminators appended in hex-ASCII mode
//   calcBaudDiv   : clock cycles per UART bit (integer division)
//   nibbleToAscii : 4-bit value to upper-case ASCII hex digit
// ---------------------------------------------------------------------------
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DONE
  } seq_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Truncating division: the bit period is rounded down to whole clocks.
  function automatic int calcBaudDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // '0'..'9' map to 0x30..0x39, 'A'..'F' to 0x41..0x46 (0x37 + 10 = 0x41).
  function automatic logic [7:0] nibbleToAscii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser for one byte: start bit (0), eight data bits LSB first,
// stop bit (1), each held BAUD_DIV clock cycles.
// A byte is accepted when valid_i && ready_o. ready_o is high while idle and
// in the final cycle of the stop bit, so a byte offered then starts its start
// bit directly after the stop bit with no idle gap.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (line returns high at once)
//   valid_i : byte available on data_i
//   data_i  : byte to send
//   ready_o : byte on data_i is taken this cycle if valid_i is high
//   tx_o    : serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_byte
  import simon_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bitEnd;

  // State, bit-period counter, data bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
    end
  end

  // Line level is decoded straight from the state register so that an
  // asynchronous reset drives the line high without waiting for a clock.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    ready_o   = 1'b0;
    tx_o      = 1'b1;
    bitEnd    = (baudCnt_q == BIT_LAST);

    case (state_q)
      IDLE: begin
        ready_o   = 1'b1;
        baudCnt_d = '0;
        bitIdx_d  = '0;
        if (valid_i) begin
          shift_d = data_i;
          state_d = START;
        end
      end

      START: begin
        tx_o = 1'b0;
        if (bitEnd) begin
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      DATA: begin
        tx_o = shift_q[0];
        if (bitEnd) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      STOP: begin
        tx_o = 1'b1;
        if (bitEnd) begin
          ready_o   = 1'b1;
          baudCnt_d = '0;
          if (valid_i) begin
            shift_d = data_i;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/simon_dout_uart_tx.sv
// ---------------------------------------------------------------------------
// simon_dout_uart_tx
// Captures the 2N-bit Simon result word and sends it over an 8N1 UART line,
// most-significant byte first, frames back to back.
// Build option: define SIMON_TX_HEX_ASCII_EN to send each byte as two
// upper-case ASCII hex characters (high nibble first) followed by CR LF;
// left undefined, the raw bytes are sent.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : result word from the cipher core
//   done  : cipher core done level
//   send  : one-cycle re-send request, honoured only while done is high
//   tx    : UART line, idle high
//   busy  : high from the first start bit to the end of the last stop bit
//   sent  : one-cycle pulse in the cycle after the last stop bit
// ---------------------------------------------------------------------------
module simon_dout_uart_tx
  import simon_pkg::*;
#(
  parameter int N        = 16,
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2*N-1:0] din,
  input  logic         done,
  input  logic         send,
  output logic         tx,
  output logic         busy,
  output logic         sent
);

  localparam int BAUD_DIV = calcBaudDiv(CLK_FREQ, BAUD);
  localparam int W        = 2 * N;
  localparam int NBYTES   = W / 8;
`ifdef SIMON_TX_HEX_ASCII_EN
  localparam int NCHARS   = 2 * NBYTES + 2;
`else
  localparam int NCHARS   = NBYTES;
`endif
  localparam int IW       = $clog2(NCHARS + 1);

  seq_state_e    seq_q, seq_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [IW-1:0] charIdx_q, charIdx_d;
  logic          doneDly_q;

  logic          trigger;
  logic [W-1:0]  wordSel;
  logic [IW-1:0] idxSel;
  logic          txValid;
  logic          txReady;
  logic [7:0]    txData;

  // Byte k of the word, counted from the most-significant end.
  function automatic logic [7:0] byteAt(input logic [W-1:0] word, input int k);
    logic [W-1:0] sh;
    sh = word >> (W - 8 - 8 * k);
    return sh[7:0];
  endfunction

  // Character number idx of the outgoing stream for a given word.
  function automatic logic [7:0] charAt(input logic [W-1:0] word, input int idx);
    logic [7:0] b;
`ifdef SIMON_TX_HEX_ASCII_EN
    if (idx < 2 * NBYTES) begin
      b = byteAt(word, idx / 2);
      if ((idx % 2) == 0) begin
        return nibbleToAscii(b[7:4]);
      end
      return nibbleToAscii(b[3:0]);
    end
    if (idx == 2 * NBYTES) begin
      return CHAR_CR;
    end
    return CHAR_LF;
`else
    b = byteAt(word, idx);
    return b;
`endif
  endfunction

  // The delayed copy of done resets high so that a done level already held
  // across reset is not mistaken for a fresh completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneDly_q <= 1'b1;
    end else begin
      doneDly_q <= done;
    end
  end

  // Sequencer state, latched word and index of the next character to hand
  // to the serialiser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q     <= SEQ_IDLE;
      shadow_q  <= '0;
      charIdx_q <= '0;
    end else begin
      seq_q     <= seq_d;
      shadow_q  <= shadow_d;
      charIdx_q <= charIdx_d;
    end
  end

  assign trigger = (done & ~doneDly_q) | (send & done);

  // The first character is handed over on the trigger edge itself, before
  // the shadow register holds the word, so it is taken from din directly.
  assign wordSel = (seq_q == SEQ_IDLE) ? din : shadow_q;
  assign idxSel  = (seq_q == SEQ_IDLE) ? '0 : charIdx_q;
  assign txData  = charAt(wordSel, int'(idxSel));

  // Triggers are looked at only in idle; anything arriving while sending or
  // in the done cycle is dropped.
  always_comb begin
    seq_d     = seq_q;
    shadow_d  = shadow_q;
    charIdx_d = charIdx_q;
    txValid   = 1'b0;

    case (seq_q)
      SEQ_IDLE: begin
        if (trigger && txReady) begin
          shadow_d  = din;
          txValid   = 1'b1;
          charIdx_d = IW'(1);
          seq_d     = SEQ_SEND;
        end
      end

      SEQ_SEND: begin
        if (charIdx_q < IW'(NCHARS)) begin
          txValid = 1'b1;
          if (txReady) begin
            charIdx_d = charIdx_q + 1'b1;
          end
        end else if (txReady) begin
          seq_d = SEQ_DONE;
        end
      end

      SEQ_DONE: begin
        charIdx_d = '0;
        seq_d     = SEQ_IDLE;
      end

      default: begin
        seq_d = SEQ_IDLE;
      end
    endcase
  end

  assign busy = (seq_q == SEQ_SEND);
  assign sent = (seq_q == SEQ_DONE);

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) uTxByte (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(txValid),
    .data_i (txData),
    .ready_o(txReady),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_simon_dout_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_simon_dout_uart_tx
// Directed bench for simon_dout_uart_tx with a short bit period
// (50 MHz / 4 Mbaud -> 12 clocks per bit after truncation).
// Honours SIMON_TX_HEX_ASCII_EN for its expected character stream.
// ---------------------------------------------------------------------------
module tb_simon_dout_uart_tx;

  localparam int DIV = 12;
  localparam logic [31:0] WORD = 32'hC69BE9BB;

`ifdef SIMON_TX_HEX_ASCII_EN
  localparam int NCH = 10;
  localparam logic [9:0] FRAME0 = 10'b1010000110;
  localparam int RST_AT = 11 * DIV + DIV / 2;
  logic [7:0] expChars [NCH] = '{8'h43, 8'h36, 8'h39, 8'h42, 8'h45,
                                 8'h39, 8'h42, 8'h42, 8'h0D, 8'h0A};
`else
  localparam int NCH = 4;
  localparam logic [9:0] FRAME0 = 10'b1110001100;
  localparam int RST_AT = 13 * DIV + DIV / 2;
  logic [7:0] expChars [NCH] = '{8'hC6, 8'h9B, 8'hE9, 8'hBB};
`endif
  localparam int EXP_LEN = NCH * 10 * DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        done;
  logic        send;
  logic        tx;
  logic        busy;
  logic        sent;

  int   vectors;
  int   miscompares;
  logic capTx[$];
  int   sentSeen;
  int   busyCnt;
  int   lowCnt;

  simon_dout_uart_tx #(
    .N       (16),
    .CLK_FREQ(50_000_000),
    .BAUD    (4_000_000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .done (done),
    .send (send),
    .tx   (tx),
    .busy (busy),
    .sent (sent)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait somewhere never completes.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic dn, input logic sd);
    din  = d;
    done = dn;
    send = sd;
  endtask

  function automatic logic expBit(input int i);
    int f;
    int p;
    logic [7:0] c;
    f = i / (10 * DIV);
    p = (i % (10 * DIV)) / DIV;
    c = expChars[f];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return c[p-1];
  endfunction

  // Record tx every cycle while busy, then count sent pulses around the end.
  task automatic captureTx();
    capTx.delete();
    sentSeen = 0;
    while (busy === 1'b1 && capTx.size() < EXP_LEN + 100) begin
      capTx.push_back(tx);
      @(negedge clk);
    end
    if (sent === 1'b1) sentSeen++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sent === 1'b1) sentSeen++;
    end
  endtask

  task automatic countActivity(input int cycles);
    busyCnt = 0;
    lowCnt  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busyCnt++;
      if (tx !== 1'b1) lowCnt++;
    end
  endtask

  task automatic analyzeTx(input string tag);
    int errs;
    int idx;
    logic [7:0] got;
    logic [9:0] f0;
    checkOutput({tag, "_len"}, capTx.size(), EXP_LEN);
    errs = 0;
    for (int i = 0; i < capTx.size() && i < EXP_LEN; i++) begin
      if (capTx[i] !== expBit(i)) errs++;
    end
    checkOutput({tag, "_bits"}, errs, 0);
    for (int c = 0; c < NCH; c++) begin
      got = 'x;
      for (int b = 0; b < 8; b++) begin
        idx = c * 10 * DIV + (b + 1) * DIV + DIV / 2;
        if (idx < capTx.size()) got[b] = capTx[idx];
      end
      checkOutput($sformatf("%s_char%0d", tag, c), {24'h0, got}, {24'h0, expChars[c]});
    end
    f0 = 'x;
    for (int j = 0; j < 10; j++) begin
      idx = j * DIV + DIV / 2;
      if (idx < capTx.size()) f0[j] = capTx[idx];
    end
    checkOutput({tag, "_frame0"}, {22'h0, f0}, {22'h0, FRAME0});
    checkOutput({tag, "_sent"}, sentSeen, 1);
    checkOutput({tag, "_txidle"}, {31'h0, tx}, 32'h1);
  endtask

  // Directed sequence; every drive and sample happens on the falling edge.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'h0, tx}, 32'h1);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_sent", {31'h0, sent}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // done rising starts a transmission of the latched word
    applyStimulus(WORD, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t1_start_tx", {31'h0, tx}, 32'h0);
    checkOutput("t1_start_busy", {31'h0, busy}, 32'h1);
    captureTx();
    analyzeTx("t1");

    // send and a done re-rise while busy are dropped
    applyStimulus(WORD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(WORD, 1'b1, 1'b0);
    @(negedge clk);
    fork
      captureTx();
      begin
        repeat (40) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (50) @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        done = 1'b1;
        din  = 32'h12345678;
      end
    join
    analyzeTx("t2");
    countActivity(60);
    checkOutput("t2_noretx_busy", busyCnt, 0);

    // send with done high repeats the word once; send with done low is ignored
    applyStimulus(WORD, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t3_start_busy", {31'h0, busy}, 32'h1);
    applyStimulus(WORD, 1'b1, 1'b0);
    captureTx();
    analyzeTx("t3");
    countActivity(30);
    checkOutput("t3_held_busy", busyCnt, 0);
    applyStimulus(WORD, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(WORD, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(WORD, 1'b0, 1'b0);
    countActivity(60);
    checkOutput("t3_nodone_busy", busyCnt, 0);
    checkOutput("t3_nodone_tx", lowCnt, 0);

    // din cleared one cycle after the trigger does not reach the line
    applyStimulus(WORD, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0, 1'b1, 1'b0);
    captureTx();
    analyzeTx("t4");

    // reset in the second frame's data bits idles the line immediately
    applyStimulus(WORD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(WORD, 1'b1, 1'b0);
    repeat (RST_AT + 1) @(negedge clk);
    checkOutput("t5_pre_busy", {31'h0, busy}, 32'h1);
    checkOutput("t5_pre_tx", {31'h0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_tx", {31'h0, tx}, 32'h1);
    checkOutput("t5_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    countActivity(60);
    checkOutput("t5_idle_busy", busyCnt, 0);
    checkOutput("t5_idle_tx", lowCnt, 0);
    applyStimulus(WORD, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(WORD, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_restart_tx", {31'h0, tx}, 32'h0);
    captureTx();
    analyzeTx("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
